// File: rtl/instruction_fetch_queue_if.sv
// rtl/instruction_fetch_queue_if.sv - fetch queue memory, redirect and decoder-facing signals
interface instruction_fetch_queue_if #(
    parameter int QDEPTH = 4
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          id_stall;
    logic          inst_valid;
    logic [31:0]   inst_word;
    logic [31:0]   inst_pc;
    logic [4:0]    inst_read_reg_addr1;
    logic [4:0]    inst_read_reg_addr2;
    logic [4:0]    rd;
    logic [15:0]   inst_imm_field;
    logic [CW-1:0] queue_count;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redirect, redirect_pc, id_stall,
        output inst_valid, inst_word, inst_pc,
        output inst_read_reg_addr1, inst_read_reg_addr2, rd, inst_imm_field,
        output queue_count
    );

    // Memory / pipeline side
    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redirect, redirect_pc, id_stall,
        input  inst_valid, inst_word, inst_pc,
        input  inst_read_reg_addr1, inst_read_reg_addr2, rd, inst_imm_field,
        input  queue_count
    );
endinterface

// File: rtl/instruction_fetch_queue.sv
// rtl/instruction_fetch_queue.sv - PC tracking, single-outstanding fetch and instruction FIFO
module instruction_fetch_queue #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic clk,
    input  logic reset,
    instruction_fetch_queue_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          drop_pending;
    logic [31:0]   q_word [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          head_valid;
    logic [CW:0]   inflight;
    logic          issue;
    logic          push;
    logic          pop;
    logic [31:0]   head_word;
    logic [31:0]   head_pc;
    logic [1:0]    redirect_pc_unused;

    assign redirect_pc_unused = bus.redirect_pc[1:0];

    assign head_valid = (count != '0);
    // Slots already committed: stored entries plus the one in flight; a pop this cycle is not credited
    assign inflight   = {1'b0, count} + {{CW{1'b0}}, outstanding};
    assign issue      = !reset && !bus.redirect && (!outstanding || bus.imem_rvalid)
                        && !drop_pending && (inflight < (CW+1)'(QDEPTH));
    assign push       = bus.imem_rvalid && !drop_pending && !bus.redirect;
    assign pop        = head_valid && !bus.id_stall && !bus.redirect;

    // Fetch control, FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            req_pc       <= RESET_PC;
            outstanding  <= 1'b0;
            drop_pending <= 1'b0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
        end else if (bus.redirect) begin
            fetch_pc     <= {bus.redirect_pc[31:2], 2'b00};
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            // A request still in flight will come back stale and must be swallowed
            drop_pending <= outstanding && !bus.imem_rvalid;
            if (bus.imem_rvalid) begin
                outstanding <= 1'b0;
            end
        end else begin
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                req_pc      <= fetch_pc;
                outstanding <= 1'b1;
            end else if (bus.imem_rvalid) begin
                outstanding <= 1'b0;
            end
            if (bus.imem_rvalid) begin
                drop_pending <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while count is zero, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr_ptr] <= bus.imem_rdata;
            q_pc[wr_ptr]   <= req_pc;
        end
    end

    assign head_word = head_valid ? q_word[rd_ptr] : 32'h0;
    assign head_pc   = head_valid ? q_pc[rd_ptr]   : 32'h0;

    assign bus.imem_req            = issue;
    assign bus.imem_addr           = fetch_pc;
    assign bus.inst_valid          = head_valid;
    assign bus.inst_word           = head_word;
    assign bus.inst_pc             = head_pc;
    assign bus.inst_read_reg_addr1 = head_word[25:21];
    assign bus.inst_read_reg_addr2 = head_word[20:16];
    assign bus.rd                  = head_word[15:11];
    assign bus.inst_imm_field      = head_word[15:0];
    assign bus.queue_count         = count;
endmodule
